// File: rtl/cache_set_assoc.sv
// N-way set-associative write-back, write-allocate data cache between a 32-bit
// word pipeline port and a 128-bit block memory, with saturating hit/miss counters.
module cache_set_assoc #(
  parameter int SET_BITS = 2,
  parameter int WAY_BITS = 1,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               proc_reset_n,
  input  logic               proc_read,
  input  logic               proc_write,
  input  logic [29:0]        proc_addr,
  input  logic [31:0]        proc_wdata,
  output logic [31:0]        proc_rdata,
  output logic               proc_stall,
  output logic               mem_read,
  output logic               mem_write,
  output logic [27:0]        mem_addr,
  output logic [127:0]       mem_wdata,
  input  logic [127:0]       mem_rdata,
  input  logic               mem_ready,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count
);

  localparam int NSETS = 1 << SET_BITS;
  localparam int NWAYS = 1 << WAY_BITS;
  localparam int WW    = (WAY_BITS > 0) ? WAY_BITS : 1;
  localparam int TAG_W = 28 - SET_BITS;

  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  state_t             state_q;
  logic               prev_cmp_q;
  logic [WW-1:0]      victim_q;
  logic               victim_rr_q;
  logic [CNT_W-1:0]   hit_q;
  logic [CNT_W-1:0]   miss_q;

  logic               valid_q [NSETS][NWAYS];
  logic               dirty_q [NSETS][NWAYS];
  logic [TAG_W-1:0]   tag_q   [NSETS][NWAYS];
  logic [127:0]       data_q  [NSETS][NWAYS];
  logic [WW-1:0]      rr_q    [NSETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic [1:0]          word;
  logic                req;

  assign idx  = proc_addr[SET_BITS+1:2];
  assign tag  = proc_addr[29:SET_BITS+2];
  assign word = proc_addr[1:0];
  assign req  = proc_read | proc_write;

  logic [NWAYS-1:0] hit_vec;
  logic [NWAYS-1:0] inv_vec;

  generate
    for (genvar gi = 0; gi < NWAYS; gi++) begin : g_way
      assign hit_vec[gi] = valid_q[idx][gi] && (tag_q[idx][gi] == tag);
      assign inv_vec[gi] = !valid_q[idx][gi];
    end
  endgenerate

  logic          hit;
  logic [WW-1:0] hit_way;
  logic          has_inv;
  logic [WW-1:0] inv_way;

  // Descending scan so the lowest-index match wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (inv_vec[w]) begin
        has_inv = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  logic [WW-1:0]  victim_sel;
  logic [WW-1:0]  rr_next;
  logic [127:0]   hit_line;
  logic [31:0]    hit_word;
  logic           victim_dirty;

  assign victim_sel   = has_inv ? inv_way : rr_q[idx];
  assign rr_next      = (NWAYS == 1) ? '0 : WW'(rr_q[idx] + 1'b1);
  assign hit_line     = data_q[idx][hit_way];
  assign hit_word     = hit_line[{word, 5'd0} +: 32];
  assign victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];

  always_comb begin
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_COMPARE: begin
        if (req) begin
          proc_stall = ~hit;
          if (hit && proc_read) proc_rdata = hit_word;
        end
      end
      S_WRITEBACK: begin
        proc_stall = 1'b1;
        mem_addr   = {tag_q[idx][victim_q], idx};
        mem_wdata  = data_q[idx][victim_q];
        mem_write  = ~mem_ready;
      end
      S_ALLOCATE: begin
        proc_stall = 1'b1;
        mem_addr   = proc_addr[29:2];
        mem_read   = ~mem_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= S_COMPARE;
      prev_cmp_q  <= 1'b1;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      hit_q       <= '0;
      miss_q      <= '0;
      for (int s = 0; s < NSETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NWAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      prev_cmp_q <= (state_q == S_COMPARE);
      case (state_q)
        S_COMPARE: begin
          if (req) begin
            if (hit) begin
              if (proc_write) dirty_q[idx][hit_way] <= 1'b1;
              // The completion right after a fill is not a fresh hit.
              if (prev_cmp_q && (hit_q != '1)) hit_q <= hit_q + 1'b1;
            end else begin
              victim_q    <= victim_sel;
              victim_rr_q <= ~has_inv;
              if (miss_q != '1) miss_q <= miss_q + 1'b1;
              state_q     <= victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            dirty_q[idx][victim_q] <= 1'b0;
            state_q                <= S_ALLOCATE;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
            if (victim_rr_q) rr_q[idx] <= rr_next;
            state_q <= S_COMPARE;
          end
        end
        default: state_q <= S_COMPARE;
      endcase
    end
  end

  // Tag and data payload carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state_q == S_COMPARE && req && hit && proc_write)
      data_q[idx][hit_way][{word, 5'd0} +: 32] <= proc_wdata;
    if (state_q == S_ALLOCATE && mem_ready) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_set_assoc.sv
// Directed bench for cache_set_assoc: hand-computed vectors for fills, hits,
// eviction, write-miss merge, mid-writeback reset and counter saturation.
module tb_cache_set_assoc;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [3:0]   hit_count, miss_count;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [127:0] D1  = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [127:0] D2  = {32'hBBBBBBBB, 32'hAAAAAAAA, 32'h99999999, 32'h88888888};
  localparam logic [127:0] D3  = {32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC};
  localparam logic [127:0] D1W = {32'h44444444, 32'h33333333, 32'h22222222, 32'hDEADBEEF};
  localparam logic [127:0] DM  = {32'h44444444, 32'h33333333, 32'hCAFEF00D, 32'hDEADBEEF};

  cache_set_assoc #(.SET_BITS(2), .WAY_BITS(1), .CNT_W(4)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (proc_read),
    .proc_write   (proc_write),
    .proc_addr    (proc_addr),
    .proc_wdata   (proc_wdata),
    .proc_rdata   (proc_rdata),
    .proc_stall   (proc_stall),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
    @(negedge clk);
    proc_read  = r;
    proc_write = w;
    proc_addr  = a;
    proc_wdata = d;
    #1;
  endtask

  task automatic hold();
    @(negedge clk);
    #1;
  endtask

  // Called in the first ALLOCATE cycle; returns in the completing COMPARE cycle.
  task automatic fill(input string name, input logic [27:0] ea, input logic [127:0] d);
    chk({name, "_mrd"}, mem_read, 1'b1);
    chk({name, "_maddr"}, mem_addr, ea);
    chk({name, "_mwr"}, mem_write, 1'b0);
    mem_rdata = d;
    mem_ready = 1'b1;
    #1;
    chk({name, "_mrd_drop"}, mem_read, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    #1;
    chk({name, "_done_stall"}, proc_stall, 1'b0);
  endtask

  task automatic hit_read(input string name, input logic [29:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    chk({name, "_stall"}, proc_stall, 1'b0);
    chk({name, "_rdata"}, proc_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    proc_reset_n = 1'b0;
    proc_read    = 1'b0;
    proc_write   = 1'b0;
    proc_addr    = '0;
    proc_wdata   = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;

    hold();
    chk("rst_stall", proc_stall, 1'b0);
    chk("rst_rdata", proc_rdata, 32'h0);
    chk("rst_mrd", mem_read, 1'b0);
    chk("rst_mwr", mem_write, 1'b0);
    chk("rst_maddr", mem_addr, 28'h0);
    chk("rst_mwdata", mem_wdata, 128'h0);
    chk("rst_hits", hit_count, 4'd0);
    chk("rst_miss", miss_count, 4'd0);
    @(negedge clk);
    proc_reset_n = 1'b1;

    // First read miss, fill, then three hits in the same block.
    drive(1'b1, 1'b0, 30'h10, 32'h0);
    chk("m1_stall", proc_stall, 1'b1);
    chk("m1_mrd_cmp", mem_read, 1'b0);
    hold();
    chk("m1_miss", miss_count, 4'd1);
    fill("m1", 28'h4, D1);
    chk("m1_rdata", proc_rdata, 32'h11111111);
    hit_read("h11", 30'h11, 32'h22222222);
    hit_read("h12", 30'h12, 32'h33333333);
    hit_read("h13", 30'h13, 32'h44444444);
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    chk("c1_hits", hit_count, 4'd3);
    chk("c1_miss", miss_count, 4'd1);

    // Second block in the same set fills the invalid way, no writeback.
    drive(1'b1, 1'b0, 30'h110, 32'h0);
    chk("m2_stall", proc_stall, 1'b1);
    hold();
    chk("m2_no_wb", mem_write, 1'b0);
    fill("m2", 28'h44, D2);
    chk("m2_rdata", proc_rdata, 32'h88888888);
    hit_read("h10", 30'h10, 32'h11111111);
    hit_read("h113", 30'h113, 32'hBBBBBBBB);

    // Dirty the first block, then evict it (round-robin pointer is 0).
    drive(1'b0, 1'b1, 30'h10, 32'hDEADBEEF);
    chk("wr_hit_stall", proc_stall, 1'b0);
    drive(1'b1, 1'b0, 30'h210, 32'h0);
    chk("m3_stall", proc_stall, 1'b1);
    hold();
    chk("wb_mwr", mem_write, 1'b1);
    chk("wb_mrd", mem_read, 1'b0);
    chk("wb_maddr", mem_addr, 28'h4);
    chk("wb_mwdata", mem_wdata, D1W);
    chk("wb_stall", proc_stall, 1'b1);
    hold();
    chk("wb_wait_mwr", mem_write, 1'b1);
    mem_ready = 1'b1;
    #1;
    chk("wb_mwr_drop", mem_write, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    fill("m3", 28'h84, D3);
    chk("m3_rdata", proc_rdata, 32'hCCCCCCCC);

    // Write miss: victim is way 1 (clean), word merges after the fill.
    drive(1'b0, 1'b1, 30'h11, 32'hCAFEF00D);
    chk("wm_stall", proc_stall, 1'b1);
    hold();
    chk("wm_no_wb", mem_write, 1'b0);
    fill("wm", 28'h4, D1W);
    hit_read("wm_merged", 30'h11, 32'hCAFEF00D);
    hit_read("wm_keep", 30'h10, 32'hDEADBEEF);
    hit_read("wm_way0", 30'h210, 32'hCCCCCCCC);

    // Evict way 0, then the merged dirty block in way 1 is written back.
    drive(1'b1, 1'b0, 30'h110, 32'h0);
    chk("m5_stall", proc_stall, 1'b1);
    hold();
    chk("m5_no_wb", mem_write, 1'b0);
    fill("m5", 28'h44, D2);
    drive(1'b1, 1'b0, 30'h212, 32'h0);
    chk("m6_stall", proc_stall, 1'b1);
    hold();
    chk("wb2_mwr", mem_write, 1'b1);
    chk("wb2_maddr", mem_addr, 28'h4);
    chk("wb2_mwdata", mem_wdata, DM);
    chk("c2_hits", hit_count, 4'd9);
    chk("c2_miss", miss_count, 4'd6);

    // Asynchronous reset in the middle of the writeback.
    proc_reset_n = 1'b0;
    #1;
    chk("rstwb_mwr", mem_write, 1'b0);
    chk("rstwb_hits", hit_count, 4'd0);
    chk("rstwb_miss", miss_count, 4'd0);
    proc_read = 1'b0;
    #1;
    chk("rstwb_stall", proc_stall, 1'b0);
    chk("rstwb_maddr", mem_addr, 28'h0);
    chk("rstwb_mwdata", mem_wdata, 128'h0);
    @(negedge clk);
    proc_reset_n = 1'b1;
    drive(1'b1, 1'b0, 30'h110, 32'h0);
    chk("prst_miss_stall", proc_stall, 1'b1);
    hold();
    fill("prst", 28'h44, D2);
    chk("prst_rdata", proc_rdata, 32'h88888888);

    // Counter saturation at 4 bits.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 30'h110 + 30'(i % 4), 32'h0);
      chk("sat_hit_stall", proc_stall, 1'b0);
    end
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    chk("sat_hits", hit_count, 4'd15);
    chk("sat_miss", miss_count, 4'd1);

    // Read and write together behave as a write.
    drive(1'b1, 1'b1, 30'h112, 32'h5A5A5A5A);
    chk("rw_stall", proc_stall, 1'b0);
    hit_read("rw_upd", 30'h112, 32'h5A5A5A5A);
    hit_read("rw_other", 30'h113, 32'hBBBBBBBB);
    drive(1'b0, 1'b0, 30'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
